// File: rtl/fwd_pkg.sv
// Shared types and latency constants for the hazard/forwarding scoreboard.
// Tags are stored at fixed maximum widths so one packed type serves every parameterisation.
package fwd_pkg;

   localparam int TAG_AW = 8;
   localparam int TAG_TW = 4;

   typedef logic [TAG_AW-1:0] tag_addr_t;
   typedef logic [TAG_TW-1:0] tag_tnew_t;

   typedef struct packed {
      logic      valid;
      tag_addr_t addr;
      tag_tnew_t tnew;
   } tag_t;

   localparam int TUSE_D    = 0;
   localparam int TUSE_E    = 1;
   localparam int TNEW_ALU  = 1;
   localparam int TNEW_LOAD = 2;
   localparam int TNEW_LINK = 0;

   function automatic tag_tnew_t tnew_dec(input tag_tnew_t t);
      return (t == '0) ? '0 : t - tag_tnew_t'(1);
   endfunction

   // One pipeline step: the entry moves one stage older and its remaining latency shrinks.
   function automatic tag_t tag_age(input tag_t t);
      tag_t r;
      r      = t;
      r.tnew = tnew_dec(t.tnew);
      return r;
   endfunction

endpackage

// File: rtl/fwd_match.sv
// Youngest-match search over tag entries FIRST..DEPTH for one source address.
// Returns hit, the 1-based stage k of the match, its remaining tnew, and ready (tnew==0).
module fwd_match
   import fwd_pkg::*;
#(
   parameter int DEPTH = 3,
   parameter int FIRST = 1,
   parameter int K_W   = 2
) (
   input  tag_t [DEPTH-1:0] tags,
   input  tag_addr_t        addr,
   output logic             hit,
   output logic [K_W-1:0]   k,
   output tag_tnew_t        tnew,
   output logic             ready
);

   // Scan oldest to youngest so the youngest (lowest k) match is the one left standing.
   always_comb begin
      hit  = 1'b0;
      k    = '0;
      tnew = '0;
      for (int j = DEPTH; j >= FIRST; j--) begin
         if (tags[j-1].valid && (addr != '0) && (tags[j-1].addr == addr)) begin
            hit  = 1'b1;
            k    = K_W'(j);
            tnew = tags[j-1].tnew;
         end
      end
   end

   assign ready = hit && (tnew == '0);

endmodule

// File: rtl/fwd_scoreboard.sv
// Destination-tag pipeline with Tnew countdown: produces the decode stall and the
// forwarded operands for decode-stage and execute-stage consumers.
module fwd_scoreboard
   import fwd_pkg::*;
#(
   parameter int NUM_SRC = 2,
   parameter int DEPTH   = 3,
   parameter int DATA_W  = 32,
   parameter int REG_AW  = 5,
   parameter int TNEW_W  = 2
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      d_valid,
   input  logic                      d_we,
   input  logic [REG_AW-1:0]         d_dst,
   input  logic [TNEW_W-1:0]         d_tnew,
   input  logic                      flush,
   input  logic [NUM_SRC-1:0]        src_en,
   input  logic [NUM_SRC*REG_AW-1:0] src_addr,
   input  logic [NUM_SRC*TNEW_W-1:0] src_tuse,
   input  logic [NUM_SRC*DATA_W-1:0] rf_rdata,
   input  logic [DEPTH*DATA_W-1:0]   stage_data,
   output logic                      stall,
   output logic [NUM_SRC*DATA_W-1:0] d_opnd,
   output logic [NUM_SRC*DATA_W-1:0] e_opnd
);

   localparam int K_W = $clog2(DEPTH + 1);

   tag_t [DEPTH-1:0]   tags;
   logic [NUM_SRC-1:0] src_stall;
   logic               bubble;

   assign stall  = |src_stall;
   assign bubble = stall | flush;

   // tags[k-1] holds entry t[k]; a stall or flush enters an invalid entry exactly once.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tags <= '0;
      end else begin
         tags[0] <= '{valid: d_valid & d_we & ~bubble,
                      addr:  tag_addr_t'(d_dst),
                      tnew:  tag_tnew_t'(d_tnew)};
         for (int j = 1; j < DEPTH; j++) begin
            tags[j] <= tag_age(tags[j-1]);
         end
      end
   end

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      tag_addr_t         addr;
      tag_tnew_t         tuse;
      logic [DATA_W-1:0] rf_val;

      logic              d_hit;
      logic [K_W-1:0]    d_k;
      tag_tnew_t         d_tnew_m;
      logic              d_ready;
      logic [DATA_W-1:0] d_fwd;
      logic [DATA_W-1:0] d_val;

      logic              e_en_q;
      tag_addr_t         e_addr_q;
      logic [DATA_W-1:0] e_val_q;
      logic              e_hit;
      logic [K_W-1:0]    e_k;
      tag_tnew_t         e_tnew_m;
      logic              e_ready;
      logic [DATA_W-1:0] e_fwd;

      assign addr   = tag_addr_t'(src_addr[i*REG_AW +: REG_AW]);
      assign tuse   = tag_tnew_t'(src_tuse[i*TNEW_W +: TNEW_W]);
      assign rf_val = rf_rdata[i*DATA_W +: DATA_W];

      fwd_match #(
         .DEPTH (DEPTH),
         .FIRST (1),
         .K_W   (K_W)
      ) u_d_match (
         .tags  (tags),
         .addr  (addr),
         .hit   (d_hit),
         .k     (d_k),
         .tnew  (d_tnew_m),
         .ready (d_ready)
      );

      always_comb begin
         d_fwd = '0;
         for (int j = 0; j < DEPTH; j++) begin
            if (d_k == K_W'(j + 1)) d_fwd = stage_data[j*DATA_W +: DATA_W];
         end
      end

      assign src_stall[i] = src_en[i] && (addr != '0) && d_hit && (d_tnew_m > tuse);
      assign d_val        = (addr == '0) ? '0 : (d_ready ? d_fwd : rf_val);
      assign d_opnd[i*DATA_W +: DATA_W] = d_val;

      // Address and value advance every cycle; only the enable records the bubble.
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            e_en_q   <= 1'b0;
            e_addr_q <= '0;
            e_val_q  <= '0;
         end else begin
            e_en_q   <= src_en[i] & ~bubble;
            e_addr_q <= addr;
            e_val_q  <= d_val;
         end
      end

      fwd_match #(
         .DEPTH (DEPTH),
         .FIRST (2),
         .K_W   (K_W)
      ) u_e_match (
         .tags  (tags),
         .addr  (e_addr_q),
         .hit   (e_hit),
         .k     (e_k),
         .tnew  (e_tnew_m),
         .ready (e_ready)
      );

      always_comb begin
         e_fwd = '0;
         for (int j = 0; j < DEPTH; j++) begin
            if (e_k == K_W'(j + 1)) e_fwd = stage_data[j*DATA_W +: DATA_W];
         end
      end

      assign e_opnd[i*DATA_W +: DATA_W] = e_ready ? e_fwd : e_val_q;

      // An enabled E consumer must never see a still-pending producer; the stall prevents it.
      e_no_pending: assert property (@(posedge clk) disable iff (!reset_n)
                                     !(e_en_q && e_hit && !e_ready));
   end

endmodule

// File: doc/fwd_scoreboard.md
# fwd_scoreboard

Parametrised hazard and forwarding unit for the five-stage MIPS pipeline. It carries a destination-tag pipeline alongside the datapath and counts down each in-flight result's remaining production latency (Tnew). From that state it generates the decode-stage stall, plus forwarded operands for both the decode-stage consumers (comparator, jump register) and the execute-stage consumers (ALU, store data). Replaces the fixed three-way select muxes with a depth- and port-count-generic block.

## Interface
Parameters:
- `NUM_SRC`, 2: source operands per instruction (rs, rt, …)
- `DEPTH`, 3: result-producing stages after D (1=E, 2=M, 3=W)
- `DATA_W`, 32: operand width
- `REG_AW`, 5: register-address width
- `TNEW_W`, 2: Tnew/Tuse counter width

Ports:
- `clk` in 1: clock
- `reset_n` in 1: asynchronous, active-low reset
- `d_valid` in 1: real instruction in D
- `d_we` in 1: D instruction writes a register
- `d_dst` in REG_AW: destination register of the D instruction
- `d_tnew` in TNEW_W: cycles after entering E until the result exists (ALU=1, load=2, jal=0)
- `flush` in 1: kill the D instruction (insert a bubble into E)
- `src_en` in NUM_SRC: per-source read enable
- `src_addr` in NUM_SRC*REG_AW: per-source register address
- `src_tuse` in NUM_SRC*TNEW_W: 0 = consumed in D, 1 = consumed in E
- `rf_rdata` in NUM_SRC*DATA_W: register-file read data
- `stage_data` in DEPTH*DATA_W: result bus of stage k (slice k-1)
- `stall` out 1: freeze F/D, bubble E
- `d_opnd` out NUM_SRC*DATA_W: forwarded D-stage operands
- `e_opnd` out NUM_SRC*DATA_W: forwarded E-stage operands

## Operation
- Tag entry t[k], k=1..DEPTH: `valid`, `addr`, `tnew`. Only entries with valid=1 and addr≠0 match a source.
- Matching rule: for a source address, the match is the youngest (lowest k) entry whose address equals it.
- Stall condition: for any enabled source i with addr≠0, stall asserts if the youngest match has tnew > src_tuse[i].
- D forwarding: if the youngest match has tnew==0, `d_opnd[i]`=stage_data[k]. Otherwise, or with no match, `d_opnd[i]`=rf_rdata[i]. Register 0 always reads 0.
- Advance every cycle:
  - t[k] ← t[k-1] with tnew decremented, saturating at 0.
  - t[1] ← {d_valid & d_we & ~stall & ~flush, d_dst, d_tnew}.
  - Stall or flush inserts an invalid entry at t[1]; older entries still advance.
- E-side per source: on the advance, register src_en, src_addr and d_opnd. When stall or flush inserts a bubble, clear the registered enable.
- E forwarding: search t[2..DEPTH] for the youngest match.
  - Match with tnew==0: `e_opnd`=stage_data[k].
  - Otherwise: `e_opnd` is the registered D value.
  - A pending match (tnew>0) here is impossible if the stall logic is correct. Assert it in simulation.

## Timing
- Reset (async on reset_n low) clears all tags to invalid and all E-side registers to 0. Outputs: stall=0, d_opnd=rf_rdata, e_opnd=0.
- Reset deasserts synchronously to clk.
- stall, d_opnd and e_opnd are combinational from inputs and state. Tags update at the posedge.
- Forwarding latency: a result becomes forwardable in the cycle its entry's tnew reaches 0. Example: ALU result in M, or load result in W.
- Simultaneous stall and flush: the bubble is inserted exactly once.
- A flush of an instruction already in E is not this block's job. Upstream clears the E entry via d_valid=0 ordering only.
- Reset mid-stall drops all pending tags; no stall on the first cycle after reset.

## Structure
- Shared package `fwd_pkg` holds:
  - `tag_t` struct {valid, addr, tnew}
  - Tnew/Tuse localparams: TUSE_D=0, TUSE_E=1, TNEW_ALU=1, TNEW_LOAD=2, TNEW_LINK=0
- One sub-module, `fwd_match`, instantiated per source for both the D and E searches. It is a priority-encoded youngest-match search returning {hit, k, ready}.

## Test plan
- ALU r8 in E (tnew=1), D beq rs=r8 (tuse=0) → stall=1 for one cycle. Next cycle d_opnd[0]=stage_data[M].
- ALU r8 then addu using r8 (tuse=1) → no stall. e_opnd[0]=stage_data[M] value 0x1234.
- lw r9 then an E-consumer of r9 → one stall cycle. e_opnd then equals stage_data[W]=0xDEAD_BEEF.
- Writes to r0 (jal-like tnew=0 with dst=0) → never stall. d_opnd[0]=0 regardless of stage data.
- Two in-flight writes to r10 (M=5, W=7) → d_opnd=5 (youngest wins).
- Assert reset_n mid-stall with a load pending → stall=0 immediately, all tags invalid, and no forwarding after release.
